// File: rtl/add_sub_pkg.sv
// Shared types and constants for the pipelined adder/subtractor.
// Holds the result flag bundle and signed saturation limits.
package add_sub_pkg;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  // Largest positive signed n-bit value, 0x7F..F (n up to 64)
  function automatic logic [63:0] sat_max(input int unsigned n);
    return (64'd1 << (n - 32'd1)) - 64'd1;
  endfunction

  // Most negative signed n-bit value, 0x80..0 (n up to 64)
  function automatic logic [63:0] sat_min(input int unsigned n);
    return 64'd1 << (n - 32'd1);
  endfunction

endpackage

// File: rtl/add_sub_segment.sv
// One SEG-bit slice of the carry chain; b arrives already inverted for subtraction.
// cmsb is the carry into the slice's top bit, used for signed overflow on the last slice.
module add_sub_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] bx,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{SEG{1'b0}}, cin};
  assign cmsb        = sum[SEG-1] ^ a[SEG-1] ^ bx[SEG-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into SEG-bit segments,
// one per stage, with a single global advance enable for valid/ready flow control.
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int N   = 8,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic         sat,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  localparam int L  = N / SEG;
  localparam int PL = (L > 1) ? L - 1 : 1;
  localparam logic [N-1:0] S_MAX = N'(sat_max(N));
  localparam logic [N-1:0] S_MIN = N'(sat_min(N));

  if (SEG < 1 || (N % SEG) != 0) begin : g_bad_params
    $error("pipelined_add_sub: N must be a non-zero multiple of SEG");
  end

  // Partial sums fill from the top: each stage shifts down by SEG and inserts its slice
  function automatic logic [N-1:0] merge_seg(input logic [N-1:0] lo, input logic [SEG-1:0] seg);
    return (lo >> SEG) | (N'(seg) << (N - SEG));
  endfunction

  // Per-stage inputs: index 0 is the operand port, index i is the register of stage i-1
  logic           bnd_valid [L];
  logic [N-1:0]   bnd_sum   [L];
  logic [N-1:0]   bnd_a     [L];
  logic [N-1:0]   bnd_bx    [L];
  logic           bnd_cin   [L];
  logic           bnd_sat   [L];
  logic [SEG-1:0] seg_sum   [L];
  logic           seg_cout  [L];
  logic           seg_cmsb  [L];

  logic           p_valid_r [PL];
  logic [N-1:0]   p_sum_r   [PL];
  logic [N-1:0]   p_a_r     [PL];
  logic [N-1:0]   p_bx_r    [PL];
  logic           p_c_r     [PL];
  logic           p_sat_r   [PL];

  logic           adv_s;
  logic [N-1:0]   raw_s;
  logic [N-1:0]   res_s;
  flags_t         flags_s;
  flags_t         flags_r;
  logic [N-1:0]   s_r;
  logic           out_valid_r;

  assign adv_s    = !out_valid_r || out_ready;
  assign in_ready = adv_s;

  for (genvar i = 0; i < L; i++) begin : g_stage
    if (i == 0) begin : g_src_in
      assign bnd_valid[i] = in_valid;
      assign bnd_sum[i]   = '0;
      assign bnd_a[i]     = a;
      assign bnd_bx[i]    = b ^ {N{sub}};
      assign bnd_cin[i]   = sub;
      assign bnd_sat[i]   = sat;
    end else begin : g_src_pipe
      assign bnd_valid[i] = p_valid_r[i-1];
      assign bnd_sum[i]   = p_sum_r[i-1];
      assign bnd_a[i]     = p_a_r[i-1];
      assign bnd_bx[i]    = p_bx_r[i-1];
      assign bnd_cin[i]   = p_c_r[i-1];
      assign bnd_sat[i]   = p_sat_r[i-1];
    end

    add_sub_segment #(.SEG(SEG)) u_seg (
      .a    (bnd_a[i][SEG-1:0]),
      .bx   (bnd_bx[i][SEG-1:0]),
      .cin  (bnd_cin[i]),
      .sum  (seg_sum[i]),
      .cout (seg_cout[i]),
      .cmsb (seg_cmsb[i])
    );
  end

  // Intermediate stage registers; unconsumed operand bits shift down to the next slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < PL; j++) begin
        p_valid_r[j] <= 1'b0;
        p_sum_r[j]   <= '0;
        p_a_r[j]     <= '0;
        p_bx_r[j]    <= '0;
        p_c_r[j]     <= 1'b0;
        p_sat_r[j]   <= 1'b0;
      end
    end else if (adv_s) begin
      for (int j = 0; j < L - 1; j++) begin
        p_valid_r[j] <= bnd_valid[j];
        p_sum_r[j]   <= merge_seg(bnd_sum[j], seg_sum[j]);
        p_a_r[j]     <= bnd_a[j] >> SEG;
        p_bx_r[j]    <= bnd_bx[j] >> SEG;
        p_c_r[j]     <= seg_cout[j];
        p_sat_r[j]   <= bnd_sat[j];
      end
    end
  end

  // Final slice: raw flags, then optional clamp toward the sign of operand a
  always_comb begin
    raw_s         = merge_seg(bnd_sum[L-1], seg_sum[L-1]);
    flags_s.c_out = seg_cout[L-1];
    flags_s.ovf   = seg_cmsb[L-1] ^ seg_cout[L-1];
    if (bnd_sat[L-1] && flags_s.ovf) begin
      res_s = bnd_a[L-1][SEG-1] ? S_MIN : S_MAX;
    end else begin
      res_s = raw_s;
    end
    flags_s.zero = (res_s == '0);
    flags_s.neg  = res_s[N-1];
  end

  // Output registers; data only reloads when a real beat reaches the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      s_r         <= '0;
      flags_r     <= '0;
    end else if (adv_s) begin
      out_valid_r <= bnd_valid[L-1];
      if (bnd_valid[L-1]) begin
        s_r     <= res_s;
        flags_r <= flags_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign c_out     = flags_r.c_out;
  assign ovf       = flags_r.ovf;
  assign zero      = flags_r.zero;
  assign neg       = flags_r.neg;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (N=8, SEG=4): directed vectors, randomized
// streams with back-pressure against an integer-arithmetic reference, and mid-flight reset.
module tb_pipelined_add_sub;

  localparam int N   = 8;
  localparam int SEG = 4;

  localparam logic [7:0]  TA   [7] = '{8'h05, 8'h03, 8'hFF, 8'h7F, 8'h7F, 8'h80, 8'h80};
  localparam logic [7:0]  TB   [7] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
  localparam logic        TSUB [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic        TSAT [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  // {s, c_out, ovf, zero, neg}
  localparam logic [11:0] TEXP [7] = '{{8'h08, 4'b0000}, {8'hFE, 4'b0001}, {8'h00, 4'b1010},
                                       {8'h80, 4'b0101}, {8'h7F, 4'b0100}, {8'h7F, 4'b1100},
                                       {8'h80, 4'b1101}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sub = 1'b0;
  logic         sat = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] s;
  logic         c_out, ovf, zero, neg;
  logic [11:0]  got;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign got = {s, c_out, ovf, zero, neg};

  pipelined_add_sub #(.N(N), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .sat       (sat),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  // Reference: signed/unsigned integer arithmetic, returns {s, c_out, ovf, zero, neg}
  function automatic logic [11:0] model(input logic [7:0] av, input logic [7:0] bv,
                                        input logic sv, input logic tv);
    int ua, ub, sa, sb, r;
    logic [7:0] rs;
    logic c, o;
    ua = int'(av);
    ub = int'(bv);
    sa = av[7] ? ua - 256 : ua;
    sb = bv[7] ? ub - 256 : ub;
    if (sv) begin
      r = sa - sb;
      c = (ua >= ub);
    end else begin
      r = sa + sb;
      c = (ua + ub) > 255;
    end
    o  = (r > 127) || (r < -128);
    rs = 8'(r);
    if (tv && o) rs = (r > 0) ? 8'h7F : 8'h80;
    return {rs, c, o, (rs == 8'h00), rs[7]};
  endfunction

  // Presents one beat for a single cycle; caller guarantees the pipeline can accept it
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic sv, input logic tv);
    a = av; b = bv; sub = sv; sat = tv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, s, c_out, ovf, zero, neg} !== 13'd0)
      $display("FAIL reset_outputs got=%h exp=%h", {out_valid, s, c_out, ovf, zero, neg}, 13'd0);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    if ({out_valid, s, c_out, ovf, zero, neg} !== 13'd0 || in_ready !== 1'b1) failures++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(TA[i], TB[i], TSUB[i], TSAT[i]);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL directed[%0d] early_valid got=%b exp=0", i, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL directed[%0d] latency_valid got=%b exp=1", i, out_valid);
      end
      checks++;
      if (got !== TEXP[i]) begin
        failures++;
        $display("FAIL directed[%0d] result got=%h exp=%h", i, got, TEXP[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL directed[%0d] drain got=%b exp=0", i, out_valid);
      end
    end
  endtask

  task automatic test_stream(input int nbeats, input bit random_bp, input string tag);
    logic [11:0] exp_q[$];
    logic [11:0] held, expv;
    bit          holding;
    int          sent, recv, cyc;
    logic [7:0]  na, nb;
    logic        nsub, nsat;
    holding = 1'b0; held = '0; sent = 0; recv = 0; cyc = 0;
    na = 8'($urandom); nb = 8'($urandom); nsub = 1'($urandom); nsat = 1'($urandom);
    while (recv < nbeats && cyc < 300) begin
      if (random_bp) out_ready = ($urandom_range(0, 2) != 0);
      else           out_ready = !(cyc >= 4 && cyc < 7);
      in_valid = (sent < nbeats) && (!random_bp || $urandom_range(0, 3) != 0);
      a = na; b = nb; sub = nsub; sat = nsat;
      #1;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s stall_in_ready cyc=%0d got=%b exp=0", tag, cyc, in_ready);
        end
        if (holding) begin
          checks++;
          if (got !== held) begin
            failures++;
            $display("FAIL %s stall_hold cyc=%0d got=%h exp=%h", tag, cyc, got, held);
          end
        end
        held = got;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_result cyc=%0d got=%h exp=none", tag, cyc, got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin
            failures++;
            $display("FAIL %s result[%0d] got=%h exp=%h", tag, recv, got, expv);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(na, nb, nsub, nsat));
        sent++;
        na = 8'($urandom); nb = 8'($urandom); nsub = 1'($urandom); nsat = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (recv != nbeats || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s completion got=%0d exp=%0d pending=%0d", tag, recv, nbeats, exp_q.size());
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_flight;
    logic [11:0] expv;
    out_ready = 1'b1;
    a = 8'h12; b = 8'h34; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h56; b = 8'h07; sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_flight pre_valid got=%b exp=1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, s, c_out, ovf, zero, neg} !== 13'd0) begin
      failures++;
      $display("FAIL rst_flight async_clear got=%h exp=%h", {out_valid, s, c_out, ovf, zero, neg}, 13'd0);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_flight in_ready got=%b exp=1", in_ready);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_flight ghost[%0d] got=%b exp=0", i, out_valid);
      end
    end
    expv = model(8'hC8, 8'h9C, 1'b0, 1'b1);
    send(8'hC8, 8'h9C, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || got !== expv) begin
      failures++;
      $display("FAIL rst_flight after_release got=%b/%h exp=1/%h", out_valid, got, expv);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(6, 1'b0, "stall6");
    test_stream(40, 1'b1, "random_bp");
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
